// File: rtl/mac_carry_chain_if.sv
// Port bundle between the multiplier-side producer and the carry-chain accumulate stage.
// The producer drives row framing, z_j and the product; the stage returns result words, carry and err.
interface mac_carry_chain_if;
  logic        in_valid;
  logic        in_sop;
  logic        in_eop;
  logic [31:0] z_in;
  logic [63:0] p;
  logic        out_valid;
  logic        out_sop;
  logic        out_eop;
  logic [31:0] z_out;
  logic        carry_valid;
  logic [31:0] carry_out;
  logic        err;

  modport master (
    output in_valid, in_sop, in_eop, z_in, p,
    input  out_valid, out_sop, out_eop, z_out, carry_valid, carry_out, err
  );

  modport slave (
    input  in_valid, in_sop, in_eop, z_in, p,
    output out_valid, out_sop, out_eop, z_out, carry_valid, carry_out, err
  );
endinterface

// File: rtl/mac_carry_chain.sv
// Word-serial (carry, z_j) = x_i*y_j + z_j + carry stage behind the fixed-latency multiplier.
// state  | meaning: S_IDLE = waiting for a row sop; S_ROW = inside a row, cnt_q words accepted.
module mac_carry_chain #(
  parameter int MUL_LATENCY = 5,
  parameter int ROW_WORDS   = 128
) (
  input  logic               clk,
  input  logic               rst,
  mac_carry_chain_if.slave   bus
);

  localparam int CW = $clog2(ROW_WORDS + 1);
  localparam logic [CW-1:0] LAST_POS = CW'(ROW_WORDS);

  typedef enum logic [0:0] {S_IDLE, S_ROW} state_t;

  state_t state_q, state_d;

  logic [MUL_LATENCY-1:0]        dv_q, dv_d;
  logic [MUL_LATENCY-1:0]        dsop_q, dsop_d;
  logic [MUL_LATENCY-1:0]        deop_q, deop_d;
  logic [MUL_LATENCY-1:0][31:0]  dz_q, dz_d;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   carry_q, carry_d;
  logic          err_q, err_d;
  logic          out_valid_q, out_valid_d;
  logic          out_sop_q, out_sop_d;
  logic          out_eop_q, out_eop_d;
  logic [31:0]   z_out_q, z_out_d;
  logic          carry_valid_q, carry_valid_d;
  logic [31:0]   carry_out_q, carry_out_d;

  logic          d_valid, d_sop, d_eop;
  logic [31:0]   d_z;
  logic [63:0]   sum;
  logic [CW-1:0] pos;
  logic          accept;

  // Framing and z_j ride a shift line so they meet p exactly MUL_LATENCY cycles later.
  always_comb begin
    dv_d   = dv_q;
    dsop_d = dsop_q;
    deop_d = deop_q;
    dz_d   = dz_q;
    dv_d[0]   = bus.in_valid;
    dsop_d[0] = bus.in_sop;
    deop_d[0] = bus.in_eop;
    dz_d[0]   = bus.z_in;
    for (int i = 1; i < MUL_LATENCY; i++) begin
      dv_d[i]   = dv_q[i-1];
      dsop_d[i] = dsop_q[i-1];
      deop_d[i] = deop_q[i-1];
      dz_d[i]   = dz_q[i-1];
    end
  end

  assign d_valid = dv_q[MUL_LATENCY-1];
  assign d_sop   = dsop_q[MUL_LATENCY-1];
  assign d_eop   = deop_q[MUL_LATENCY-1];
  assign d_z     = dz_q[MUL_LATENCY-1];

  // Cannot overflow: (2^32-1)^2 + 2*(2^32-1) = 2^64-1.
  assign sum = bus.p + {32'h0, d_z} + {32'h0, (d_sop ? 32'h0 : carry_q)};
  assign pos = d_sop ? CW'(1) : cnt_q + CW'(1);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    carry_d       = carry_q;
    err_d         = err_q;
    out_valid_d   = 1'b0;
    out_sop_d     = 1'b0;
    out_eop_d     = 1'b0;
    carry_valid_d = 1'b0;
    z_out_d       = z_out_q;
    carry_out_d   = carry_out_q;
    accept        = 1'b0;

    if (d_valid) begin
      if (d_sop || (state_q == S_ROW)) begin
        accept = 1'b1;
      end else begin
        err_d = 1'b1;
      end
      if (d_sop && (state_q == S_ROW)) begin
        err_d = 1'b1;
      end
    end

    if (accept) begin
      out_valid_d = 1'b1;
      out_sop_d   = d_sop;
      out_eop_d   = d_eop;
      z_out_d     = sum[31:0];
      carry_d     = sum[63:32];
      if (d_eop) begin
        carry_out_d   = sum[63:32];
        carry_valid_d = 1'b1;
        state_d       = S_IDLE;
        cnt_d         = '0;
        if (pos != LAST_POS) begin
          err_d = 1'b1;
        end
      end else if (pos == LAST_POS) begin
        // Row is full but eop never came: drop the rest until the next sop.
        err_d   = 1'b1;
        state_d = S_IDLE;
        cnt_d   = '0;
      end else begin
        state_d = S_ROW;
        cnt_d   = pos;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      dv_q          <= '0;
      dsop_q        <= '0;
      deop_q        <= '0;
      dz_q          <= '0;
      cnt_q         <= '0;
      carry_q       <= '0;
      err_q         <= 1'b0;
      out_valid_q   <= 1'b0;
      out_sop_q     <= 1'b0;
      out_eop_q     <= 1'b0;
      z_out_q       <= '0;
      carry_valid_q <= 1'b0;
      carry_out_q   <= '0;
    end else begin
      state_q       <= state_d;
      dv_q          <= dv_d;
      dsop_q        <= dsop_d;
      deop_q        <= deop_d;
      dz_q          <= dz_d;
      cnt_q         <= cnt_d;
      carry_q       <= carry_d;
      err_q         <= err_d;
      out_valid_q   <= out_valid_d;
      out_sop_q     <= out_sop_d;
      out_eop_q     <= out_eop_d;
      z_out_q       <= z_out_d;
      carry_valid_q <= carry_valid_d;
      carry_out_q   <= carry_out_d;
    end
  end

  assign bus.out_valid   = out_valid_q;
  assign bus.out_sop     = out_sop_q;
  assign bus.out_eop     = out_eop_q;
  assign bus.z_out       = z_out_q;
  assign bus.carry_valid = carry_valid_q;
  assign bus.carry_out   = carry_out_q;
  assign bus.err         = err_q;

endmodule

// File: tb/tb_mac_carry_chain.sv
// Directed bench for mac_carry_chain: a 4-word-row and a 2-word-row instance share one stimulus.
// The bench models the multiplier as a 5-stage product pipe.
module tb_mac_carry_chain;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        in_valid, in_sop, in_eop;
  logic [31:0] z_in;
  logic [63:0] p_req;
  logic [63:0] p_pipe [5] = '{default: 64'h0};
  int          cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    p_pipe[0] <= in_valid ? p_req : 64'h0;
    for (int i = 1; i < 5; i++) p_pipe[i] <= p_pipe[i-1];
  end

  mac_carry_chain_if bus4();
  mac_carry_chain_if bus2();

  assign bus4.in_valid = in_valid;
  assign bus4.in_sop   = in_sop;
  assign bus4.in_eop   = in_eop;
  assign bus4.z_in     = z_in;
  assign bus4.p        = p_pipe[4];
  assign bus2.in_valid = in_valid;
  assign bus2.in_sop   = in_sop;
  assign bus2.in_eop   = in_eop;
  assign bus2.z_in     = z_in;
  assign bus2.p        = p_pipe[4];

  mac_carry_chain #(.MUL_LATENCY(5), .ROW_WORDS(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));
  mac_carry_chain #(.MUL_LATENCY(5), .ROW_WORDS(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

  typedef struct {
    logic        sop;
    logic        eop;
    logic        cv;
    logic [31:0] z;
    logic [31:0] cout;
    int          c;
  } out_t;

  out_t q4[$];
  out_t q2[$];
  int   orphan = 0;

  always @(negedge clk) begin
    if (bus4.out_valid)
      q4.push_back('{bus4.out_sop, bus4.out_eop, bus4.carry_valid, bus4.z_out, bus4.carry_out, cyc});
    if (bus2.out_valid)
      q2.push_back('{bus2.out_sop, bus2.out_eop, bus2.carry_valid, bus2.z_out, bus2.carry_out, cyc});
    if ((bus4.carry_valid && !bus4.out_valid) || (bus2.carry_valid && !bus2.out_valid))
      orphan++;
  end

  typedef struct {
    int          scn;
    int          gap;
    logic        sop;
    logic        eop;
    logic [63:0] p;
    logic [31:0] z;
    logic        emit;
    logic [31:0] ez;
    logic [31:0] ecout;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   stamps[$];
  int   cv_stamps[$];
  int   first_in;

  function automatic void add(int scn, int gap, logic sop, logic eop, logic [63:0] p,
                              logic [31:0] z, logic emit, logic [31:0] ez, logic [31:0] ecout);
    vecs.push_back('{scn, gap, sop, eop, p, z, emit, ez, ecout});
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; p_req = 64'h0; z_in = 32'h0;
  endtask

  task automatic drive(input logic sop, input logic eop, input logic [63:0] p, input logic [31:0] z);
    @(negedge clk);
    in_valid = 1'b1; in_sop = sop; in_eop = eop; p_req = p; z_in = z;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; p_req = 64'h0; z_in = 32'h0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_out_valid"},   64'(bus4.out_valid),   64'h0);
    chk({tag, "_out_sop"},     64'(bus4.out_sop),     64'h0);
    chk({tag, "_out_eop"},     64'(bus4.out_eop),     64'h0);
    chk({tag, "_z_out"},       64'(bus4.z_out),       64'h0);
    chk({tag, "_carry_valid"}, 64'(bus4.carry_valid), 64'h0);
    chk({tag, "_carry_out"},   64'(bus4.carry_out),   64'h0);
    chk({tag, "_err"},         64'(bus4.err),         64'h0);
  endtask

  task automatic run_scn(input int scn, input bit use2);
    bit   got_first;
    int   n_exp;
    out_t o;
    string tag;
    got_first = 1'b0;
    n_exp = 0;
    q4.delete(); q2.delete(); stamps.delete(); cv_stamps.delete();
    foreach (vecs[i]) begin
      if (vecs[i].scn == scn) begin
        repeat (vecs[i].gap) idle();
        drive(vecs[i].sop, vecs[i].eop, vecs[i].p, vecs[i].z);
        if (!got_first) begin
          first_in = cyc;
          got_first = 1'b1;
        end
        if (vecs[i].emit) n_exp++;
      end
    end
    repeat (12) idle();
    chk($sformatf("s%0d_n_out", scn), 64'(use2 ? q2.size() : q4.size()), 64'(n_exp));
    foreach (vecs[i]) begin
      if (vecs[i].scn == scn && vecs[i].emit && (use2 ? q2.size() : q4.size()) > 0) begin
        o = use2 ? q2.pop_front() : q4.pop_front();
        tag = $sformatf("s%0d_w%0d", scn, i);
        stamps.push_back(o.c);
        if (o.cv) cv_stamps.push_back(o.c);
        chk({tag, "_z"},   64'(o.z),   64'(vecs[i].ez));
        chk({tag, "_sop"}, 64'(o.sop), 64'(vecs[i].sop));
        chk({tag, "_eop"}, 64'(o.eop), 64'(vecs[i].eop));
        chk({tag, "_cv"},  64'(o.cv),  64'(vecs[i].eop));
        if (vecs[i].eop) chk({tag, "_cout"}, 64'(o.cout), 64'(vecs[i].ecout));
      end
    end
  endtask

  task automatic err_scn(input int scn);
    do_reset();
    chk($sformatf("s%0d_err_pre", scn), 64'(bus4.err), 64'h0);
    run_scn(scn, 1'b0);
    chk($sformatf("s%0d_err_set", scn), 64'(bus4.err), 64'h1);
    repeat (5) idle();
    chk($sformatf("s%0d_err_hold", scn), 64'(bus4.err), 64'h1);
  endtask

  initial begin
    // Scenario 1 and 3: same row, 3 idle cycles before the second word in 3.
    add(1, 0, 1, 0, 64'h1_0000_0002, 32'd1, 1, 32'd3,  32'd0);
    add(1, 0, 0, 0, 64'd5,           32'd2, 1, 32'd8,  32'd0);
    add(1, 0, 0, 0, 64'd7,           32'd3, 1, 32'd10, 32'd0);
    add(1, 0, 0, 1, 64'd9,           32'd4, 1, 32'd13, 32'd0);
    add(3, 0, 1, 0, 64'h1_0000_0002, 32'd1, 1, 32'd3,  32'd0);
    add(3, 3, 0, 0, 64'd5,           32'd2, 1, 32'd8,  32'd0);
    add(3, 0, 0, 0, 64'd7,           32'd3, 1, 32'd10, 32'd0);
    add(3, 0, 0, 1, 64'd9,           32'd4, 1, 32'd13, 32'd0);
    add(2, 0, 1, 0, 64'hFFFF_FFFE_0000_0001, 32'hFFFF_FFFF, 1, 32'h0000_0000, 32'h0);
    add(2, 0, 0, 1, 64'hFFFF_FFFE_0000_0001, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    // Back-to-back rows; the first ends with carry 3 which the second sop must drop.
    add(4, 0, 1, 0, 64'h1_0000_0002, 32'd1, 1, 32'd3,  32'd0);
    add(4, 0, 0, 0, 64'd5,           32'd2, 1, 32'd8,  32'd0);
    add(4, 0, 0, 0, 64'd7,           32'd3, 1, 32'd10, 32'd0);
    add(4, 0, 0, 1, 64'h3_0000_0009, 32'd4, 1, 32'd13, 32'd3);
    add(4, 0, 1, 0, 64'd10,          32'd1, 1, 32'd11, 32'd0);
    add(4, 0, 0, 0, 64'd20,          32'd1, 1, 32'd21, 32'd0);
    add(4, 0, 0, 0, 64'd30,          32'd1, 1, 32'd31, 32'd0);
    add(4, 0, 0, 1, 64'd40,          32'd1, 1, 32'd41, 32'd0);
    // Early eop on word 3.
    add(51, 0, 1, 0, 64'h5_0000_0001, 32'd0, 1, 32'd1, 32'd0);
    add(51, 0, 0, 0, 64'd2,           32'd0, 1, 32'd7, 32'd0);
    add(51, 0, 0, 1, 64'h7_0000_0003, 32'd0, 1, 32'd3, 32'd7);
    // Valid without sop from idle.
    add(52, 0, 0, 0, 64'd5, 32'd5, 0, 32'd0, 32'd0);
    // Sop mid-row restarts and drops carry 1.
    add(53, 0, 1, 0, 64'h1_0000_0001, 32'd0, 1, 32'd1, 32'd0);
    add(53, 0, 1, 0, 64'd4,           32'd0, 1, 32'd4, 32'd0);
    add(53, 0, 0, 0, 64'd5,           32'd0, 1, 32'd5, 32'd0);
    add(53, 0, 0, 0, 64'd6,           32'd0, 1, 32'd6, 32'd0);
    add(53, 0, 0, 1, 64'd7,           32'd0, 1, 32'd7, 32'd0);
    // Row fills without eop; the fifth word is dropped.
    add(54, 0, 1, 0, 64'd1, 32'd0, 1, 32'd1, 32'd0);
    add(54, 0, 0, 0, 64'd2, 32'd0, 1, 32'd2, 32'd0);
    add(54, 0, 0, 0, 64'd3, 32'd0, 1, 32'd3, 32'd0);
    add(54, 0, 0, 0, 64'd4, 32'd0, 1, 32'd4, 32'd0);
    add(54, 0, 0, 0, 64'd5, 32'd0, 0, 32'd0, 32'd0);

    rst = 1'b1;
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; p_req = 64'h0; z_in = 32'h0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    chk("reset_err2", 64'(bus2.err), 64'h0);
    rst = 1'b0;

    run_scn(1, 1'b0);
    if (stamps.size() > 0) chk("s1_latency", 64'(stamps[0] - first_in), 64'd6);

    run_scn(3, 1'b0);
    if (stamps.size() == 4) begin
      chk("s3_gap",  64'(stamps[1] - stamps[0]), 64'd4);
      chk("s3_next", 64'(stamps[2] - stamps[1]), 64'd1);
    end

    run_scn(4, 1'b0);
    chk("s4_n_cv", 64'(cv_stamps.size()), 64'd2);
    if (cv_stamps.size() == 2) chk("s4_cv_spacing", 64'(cv_stamps[1] - cv_stamps[0]), 64'd4);
    if (stamps.size() == 8) chk("s4_no_bubble", 64'(stamps[4] - stamps[3]), 64'd1);
    chk("clean_err", 64'(bus4.err), 64'h0);

    do_reset();
    run_scn(2, 1'b1);
    chk("s2_err", 64'(bus2.err), 64'h0);

    err_scn(51);
    err_scn(52);
    err_scn(53);
    err_scn(54);

    // Reset lands while the second word is entering and the first is in flight.
    chk("s6_err_before", 64'(bus4.err), 64'h1);
    chk("s6_z_before", 64'(bus4.z_out), 64'd4);
    drive(1'b1, 1'b0, 64'h1_0000_0002, 32'd1);
    drive(1'b0, 1'b0, 64'd5, 32'd2);
    #1 rst = 1'b1;
    #1 chk_zero("s6_async");
    q4.delete();
    @(negedge clk);
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; p_req = 64'h0; z_in = 32'h0;
    rst = 1'b0;
    repeat (12) idle();
    chk("s6_no_stale", 64'(q4.size()), 64'h0);
    run_scn(1, 1'b0);
    chk("s6_err_after", 64'(bus4.err), 64'h0);

    chk("orphan_carry_valid", 64'(orphan), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
